// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared constants, clear FSM states and lane helper for param_sp_ram
package ram_pkg;

  // Read-during-write result selection
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Clear sequencer states
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ram_state_t;

  // Number of 8-bit byte lanes in a word
  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// rtl/ram_clear_seq.sv - post-reset array clear sequencer and ready generation
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W         = 6,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  ram_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and clear counter registers; reset always restarts the clear from address 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and outputs; rst gates ready/clr_we so nothing is accepted or written at a reset edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    ready   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = rst;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        ready = rst;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign clr_addr = cnt_q;

endmodule

// File: rtl/param_sp_ram.sv
// rtl/param_sp_ram.sv - parametrised single-port RAM with byte lanes, clear and 1/2-cycle read latency
module param_sp_ram
  import ram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 6,
  parameter int READ_LAT       = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                write_en,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  output logic                ready,
  output logic [DATA_W-1:0]   dout,
  output logic                rvalid
);

  localparam int LANES = lane_count(DATA_W);
  localparam int DEPTH = 2 ** ADDR_W;

  if (DATA_W <= 0 || (DATA_W % 8) != 0) begin : g_bad_data_w
    $error("param_sp_ram: DATA_W must be a positive multiple of 8");
  end
  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
    $error("param_sp_ram: READ_LAT must be 1 or 2");
  end
  if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_FIRST) begin : g_bad_rdw
    $error("param_sp_ram: RDW_MODE must be 0 or 1");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              accept;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] resp_word;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;

  ram_clear_seq #(
    .ADDR_W        (ADDR_W),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk     (clk),
    .rst     (rst),
    .clr_we  (clr_we),
    .clr_addr(clr_addr),
    .ready   (ready)
  );

  assign accept   = en && ready;
  assign old_word = mem[addr];

  // Byte-lane merge of the write data over the currently stored word
  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) begin
        merged_word[8*i +: 8] = din[8*i +: 8];
      end
    end
  end

  // Writes report either the stored word or the merged word; reads always the stored word
  assign resp_word = (write_en && RDW_MODE == RDW_WRITE_FIRST) ? merged_word : old_word;

  // Array update: the clear sequencer owns the port until it hands over to RUN
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (accept && write_en) begin
      mem[addr] <= merged_word;
    end
  end

  // First read stage: one response per accepted access, data held between responses
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_data <= resp_word;
      end
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;

    // Output register stage adding the second cycle of latency
    always_ff @(posedge clk) begin
      if (!rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign rvalid = s2_valid;
    assign dout   = s2_data;
  end else begin : g_lat1
    assign rvalid = s1_valid;
    assign dout   = s1_data;
  end

endmodule
